// File: rtl/imm_ext_pipe.sv
// LEGv8/ARMv8 immediate extender: decodes D/CB/B/I/IW immediates on accept and
// queues results in a DEPTH-entry FIFO so decode back-pressure does not stall fetch.
module imm_ext_pipe #(
    parameter int N         = 64,
    parameter int DEPTH     = 2,
    parameter bit ENABLE_IW = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] imm,
    output logic [2:0]   fmt,
    output logic         illegal,
    output logic [15:0]  illegal_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [N-1:0]  dec_imm_s;
    logic [2:0]    dec_fmt_s;
    logic          dec_ill_s;
    logic [63:0]   movz_wide_s;
    logic          push_s;
    logic          pop_s;
    logic          unused_s;

    logic [N-1:0]  imm_mem_r [DEPTH];
    logic [2:0]    fmt_mem_r [DEPTH];
    logic          ill_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [15:0]   illegal_cnt_r;

    // Rd/Rt/opcode-low bits carry no immediate information.
    assign unused_s = ^{instr[4:0], movz_wide_s};

    // Format classification and extension, first matching pattern wins.
    always_comb begin
        dec_imm_s   = '0;
        dec_fmt_s   = 3'd0;
        dec_ill_s   = 1'b1;
        movz_wide_s = {48'd0, instr[20:5]} << {instr[22:21], 4'd0};
        if (instr[31:21] ==? 11'b1111_1000_0?0) begin
            dec_imm_s = {{(N-9){instr[20]}}, instr[20:12]};
            dec_fmt_s = 3'd1;
            dec_ill_s = 1'b0;
        end else if (instr[31:24] ==? 8'b1011_010?) begin
            dec_imm_s = {{(N-19){instr[23]}}, instr[23:5]};
            dec_fmt_s = 3'd2;
            dec_ill_s = 1'b0;
        end else if (instr[31:26] == 6'b000101) begin
            dec_imm_s = {{(N-26){instr[25]}}, instr[25:0]};
            dec_fmt_s = 3'd3;
            dec_ill_s = 1'b0;
        end else if (instr[31:22] ==? 10'b1?01_0001_00) begin
            dec_imm_s = {{(N-12){1'b0}}, instr[21:10]};
            dec_fmt_s = 3'd4;
            dec_ill_s = 1'b0;
        end else if (ENABLE_IW && (instr[31:23] == 9'b1_1010_0101)) begin
            // A 32-bit result cannot hold a halfword shifted by 32 or 48.
            if ((N == 32) && instr[22]) begin
                dec_ill_s = 1'b1;
            end else begin
                dec_imm_s = movz_wide_s[N-1:0];
                dec_fmt_s = 3'd5;
                dec_ill_s = 1'b0;
            end
        end else begin
            dec_ill_s = 1'b1;
        end
    end

    assign in_ready  = reset && (count_r != FULL_CNT);
    assign out_valid = (count_r != '0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            imm_mem_r[wr_ptr_r] <= dec_imm_s;
            fmt_mem_r[wr_ptr_r] <= dec_fmt_s;
            ill_mem_r[wr_ptr_r] <= dec_ill_s;
        end
    end

    // Queue pointers, occupancy and the saturating illegal-word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            illegal_cnt_r <= 16'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_s && dec_ill_s && (illegal_cnt_r != 16'hFFFF)) begin
                illegal_cnt_r <= illegal_cnt_r + 16'd1;
            end
        end
    end

    // Head entry presentation, forced to zero while the queue is empty.
    always_comb begin
        if (out_valid) begin
            imm     = imm_mem_r[rd_ptr_r];
            fmt     = fmt_mem_r[rd_ptr_r];
            illegal = ill_mem_r[rd_ptr_r];
        end else begin
            imm     = '0;
            fmt     = 3'd0;
            illegal = 1'b0;
        end
    end

    assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three configurations share one stimulus stream and are
// checked every cycle against a queue-based reference model plus directed literals.
module tb_imm_ext_pipe;

    typedef logic [67:0] ent_t;  // {illegal, fmt[2:0], imm[63:0]}

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr     = 32'd0;

    logic        a_rdy [3];
    logic        a_vld [3];
    logic [63:0] a_imm [3];
    logic [2:0]  a_fmt [3];
    logic        a_ill [3];
    logic [15:0] a_cnt [3];
    logic [31:0] imm1;

    int dep [3] = '{2, 3, 1};
    int nn  [3] = '{64, 32, 64};
    bit iw  [3] = '{1'b1, 1'b1, 1'b0};

    ent_t mq [3][$];
    int   mcnt [3];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.N(64), .DEPTH(2), .ENABLE_IW(1'b1)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_rdy[0]), .instr(instr),
        .out_valid(a_vld[0]), .out_ready(out_ready), .imm(a_imm[0]), .fmt(a_fmt[0]),
        .illegal(a_ill[0]), .illegal_cnt(a_cnt[0]));

    imm_ext_pipe #(.N(32), .DEPTH(3), .ENABLE_IW(1'b1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_rdy[1]), .instr(instr),
        .out_valid(a_vld[1]), .out_ready(out_ready), .imm(imm1), .fmt(a_fmt[1]),
        .illegal(a_ill[1]), .illegal_cnt(a_cnt[1]));

    imm_ext_pipe #(.N(64), .DEPTH(1), .ENABLE_IW(1'b0)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_rdy[2]), .instr(instr),
        .out_valid(a_vld[2]), .out_ready(out_ready), .imm(a_imm[2]), .fmt(a_fmt[2]),
        .illegal(a_ill[2]), .illegal_cnt(a_cnt[2]));

    assign a_imm[1] = {32'd0, imm1};

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL u%0d %s: got %0h want %0h", idx, nm, act, exp);
        end
    endtask

    task automatic head_is(input int idx, input logic [63:0] i_exp, input logic [2:0] f_exp, input logic l_exp);
        chk("head_valid", idx, 64'(a_vld[idx]), 64'd1);
        chk("head_imm", idx, a_imm[idx], i_exp);
        chk("head_fmt", idx, 64'(a_fmt[idx]), 64'(f_exp));
        chk("head_illegal", idx, 64'(a_ill[idx]), 64'(l_exp));
    endtask

    // Reference decode written as field arithmetic on the instruction word.
    function automatic ent_t ref_decode(input logic [31:0] w, input int n, input bit en);
        logic [63:0] v;
        logic [2:0]  f;
        logic        ill;
        int          hw;
        v = 64'd0; f = 3'd0; ill = 1'b1;
        hw = int'(w[22:21]);
        if ((w >> 23) == 32'h1F0 && w[21] == 1'b0) begin
            v = 64'(w[20:12]); if (w[20]) v = v - 64'd512; f = 3'd1; ill = 1'b0;
        end else if ((w >> 25) == 32'h5A) begin
            v = 64'(w[23:5]); if (w[23]) v = v - (64'd1 << 19); f = 3'd2; ill = 1'b0;
        end else if ((w >> 26) == 32'h05) begin
            v = 64'(w[25:0]); if (w[25]) v = v - (64'd1 << 26); f = 3'd3; ill = 1'b0;
        end else if (((w >> 22) & 32'h2FF) == 32'h244) begin
            v = 64'(w[21:10]); f = 3'd4; ill = 1'b0;
        end else if (en && (w >> 23) == 32'h1A5) begin
            if (n == 32 && hw >= 2) begin
                ill = 1'b1;
            end else begin
                v = 64'(w[20:5]) * (64'd1 << (16 * hw)); f = 3'd5; ill = 1'b0;
            end
        end
        if (n < 64) v = v & ((64'd1 << n) - 64'd1);
        return {ill, f, v};
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: begin w[31:23] = 9'h1F0; w[21] = 1'b0; end
            1: w[31:25] = 7'h5A;
            2: w[31:26] = 6'h05;
            3: begin w[31] = 1'b1; w[29:22] = 8'h44; end
            4, 5: w[31:23] = 9'h1A5;
            default: ;
        endcase
        return w;
    endfunction

    // Reference queues: accept/pop decided from the model's own occupancy.
    initial forever begin
        @(posedge clk or negedge reset);
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                mq[i].delete();
                mcnt[i] = 0;
            end else begin
                bit   acc;
                bit   pop;
                ent_t e;
                acc = in_valid && (mq[i].size() < dep[i]);
                pop = (mq[i].size() != 0) && out_ready;
                if (pop) void'(mq[i].pop_front());
                if (acc) begin
                    e = ref_decode(instr, nn[i], iw[i]);
                    mq[i].push_back(e);
                    if (e[67] && mcnt[i] < 65535) mcnt[i]++;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ent_t e;
            e = (mq[i].size() != 0) ? mq[i][0] : 68'd0;
            chk("out_valid", i, 64'(a_vld[i]), 64'(mq[i].size() != 0));
            chk("in_ready", i, 64'(a_rdy[i]), 64'(reset && (mq[i].size() < dep[i])));
            chk("imm", i, a_imm[i], e[63:0]);
            chk("fmt", i, 64'(a_fmt[i]), 64'(e[66:64]));
            chk("illegal", i, 64'(a_ill[i]), 64'(e[67]));
            chk("illegal_cnt", i, 64'(a_cnt[i]), 64'(mcnt[i]));
        end
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 0, 64'(a_vld[0]), 64'd0);
        chk("rst_in_ready", 0, 64'(a_rdy[0]), 64'd0);
        chk("rst_imm", 0, a_imm[0], 64'd0);
        chk("rst_cnt", 0, 64'(a_cnt[0]), 64'd0);
        #2 reset = 1'b1;
        out_ready = 1'b1;

        // Pinned examples for each format.
        @(negedge clk);
        instr = 32'hF85F8041; in_valid = 1'b1;
        @(negedge clk);
        head_is(0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0);
        head_is(1, 64'h0000_0000_FFFF_FFF8, 3'd1, 1'b0);
        instr = 32'hB4FFFF83;
        @(negedge clk);
        head_is(0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
        instr = 32'h14000010;
        @(negedge clk);
        head_is(0, 64'h10, 3'd3, 1'b0);
        instr = 32'h913FFC00;
        @(negedge clk);
        head_is(0, 64'hFFF, 3'd4, 1'b0);
        instr = 32'hD2F7DDE5;
        @(negedge clk);
        head_is(0, 64'hBEEF_0000_0000_0000, 3'd5, 1'b0);
        head_is(1, 64'd0, 3'd0, 1'b1);
        instr = 32'hD2C00020;
        @(negedge clk);
        head_is(0, 64'h0000_0001_0000_0000, 3'd5, 1'b0);
        head_is(1, 64'd0, 3'd0, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        instr = 32'hD2F7DDE5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        head_is(2, 64'd0, 3'd0, 1'b1);
        repeat (3) @(negedge clk);

        // Back-pressure: third word held while full, then FIFO drain.
        out_ready = 1'b0;
        instr = 32'h14000001; in_valid = 1'b1;
        @(negedge clk); instr = 32'h14000002;
        @(negedge clk); instr = 32'h14000003;
        @(negedge clk);
        chk("full_in_ready", 0, 64'(a_rdy[0]), 64'd0);
        head_is(0, 64'd1, 3'd3, 1'b0);
        @(negedge clk);
        chk("held_in_ready", 0, 64'(a_rdy[0]), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        head_is(0, 64'd2, 3'd3, 1'b0);
        chk("after_pop_in_ready", 0, 64'(a_rdy[0]), 64'd1);
        @(negedge clk);
        head_is(0, 64'd3, 3'd3, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drained_valid", 0, 64'(a_vld[0]), 64'd0);

        // Illegal words and their counter.
        instr = 32'h8B020020; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            head_is(0, 64'd0, 3'd0, 1'b1);
        end
        in_valid = 1'b0;
        chk("illegal_cnt3", 0, 64'(a_cnt[0]), 64'd3);

        // Asynchronous reset with a full queue.
        out_ready = 1'b0;
        instr = 32'hF85F8041; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 0, 64'(a_vld[0]), 64'd0);
        chk("async_cnt", 0, 64'(a_cnt[0]), 64'd0);
        chk("async_ready", 0, 64'(a_rdy[0]), 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        instr = 32'hF8010000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        head_is(0, 64'd16, 3'd1, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("only_output", 0, 64'(a_vld[0]), 64'd0);

        // Randomized traffic with occasional mid-stream resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = gen_word();
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                #1;
                chk("rand_rst_valid", 0, 64'(a_vld[0]), 64'd0);
                chk("rand_rst_cnt", 1, 64'(a_cnt[1]), 64'd0);
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end

        // Counter saturation.
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        instr = 32'h8B020020; in_valid = 1'b1;
        repeat (65600) @(negedge clk);
        in_valid = 1'b0;
        chk("sat_cnt", 0, 64'(a_cnt[0]), 64'hFFFF);
        chk("sat_cnt", 1, 64'(a_cnt[1]), 64'hFFFF);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Pipelined, parametrised immediate extender for the LEGv8/ARMv8 decode stage.
- Accepts 32-bit instruction words over a valid/ready handshake.
- Classifies each word as D, CB, B, I or IW format and produces the immediate sign- or zero-extended to N bits, with a format code and an illegal flag.
- Results pass through a DEPTH-entry output queue so that decode back-pressure does not stall fetch for DEPTH cycles.

Parameters:
- N, 64, output immediate width; legal values 32..64.
- DEPTH, 2, output queue entries; must be at least 1.
- ENABLE_IW, 1, when 1 MOVZ is decoded; when 0 MOVZ is illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 means in reset.
- in_valid  in  1  instr is valid.
- in_ready  out  1  queue can accept.
- instr  in  32  instruction word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- imm  out  N  extended immediate of the head entry.
- fmt  out  3  format of the head entry: 0 none, 1 D, 2 CB, 3 B, 4 I, 5 IW.
- illegal  out  1  head entry has no recognised immediate.
- illegal_cnt  out  16  saturating count of illegal words accepted.

Behaviour:
- Decode is combinational on instr and is applied only on accept (in_valid & in_ready at a rising edge). Priority is top-down:
  - D: instr[31:21] = 111_1100_00?0 (LDUR/STUR); imm = sext(instr[20:12]), 9 bits.
  - CB: instr[31:24] = 1011_010? (CBZ/CBNZ); imm = sext(instr[23:5]), 19 bits.
  - B: instr[31:26] = 000101; imm = sext(instr[25:0]), 26 bits.
  - I: instr[31:22] = 1?01_0001_00 (ADDI/SUBI); imm = zext(instr[21:10]), 12 bits.
  - IW: instr[31:23] = 1_1010_0101 (MOVZ) and ENABLE_IW=1; imm = zext(instr[20:5]) << (16*instr[22:21]). If N=32 and instr[22]=1, the entry is illegal instead.
  - Anything else: imm=0, fmt=0, illegal=1.
- No ×4 scaling of branch offsets here; downstream logic applies it.
- Queue:
  - Circular buffer with wr_ptr, rd_ptr and count; pointers wrap from DEPTH-1 to 0.
  - in_ready = (count != DEPTH) and reset deasserted. There is no pass-through when full, even if out_ready=1.
  - out_valid = (count != 0).
  - imm, fmt and illegal show the head entry; all are 0 when the queue is empty.
  - Latency: a word accepted at edge t is at the head no earlier than after edge t; out_valid rises in cycle t+1 when the queue was empty.
  - Push and pop in the same cycle: count unchanged, both pointers advance. When the queue is full only a pop can occur.
  - Order is strictly FIFO.
- illegal_cnt increments on the accept edge of an illegal word, saturates at 0xFFFF and never wraps.
- Reset, asynchronous on the falling edge of reset:
  - count=0, pointers=0, illegal_cnt=0.
  - out_valid=0, in_ready=0 while reset is low.
  - imm=0, fmt=0, illegal=0.
- Reset mid-operation discards all queued entries. The first accept after release is the first output.
- Storage contents need not be reset; outputs are masked by count.

Test Plan:
- Reset, then N=64, out_ready=1, push 0xF85F8041 (LDUR X1,[X2,#-8]) -> next cycle out_valid=1, imm=0xFFFFFFFFFFFFFFF8, fmt=1, illegal=0.
- Push 0xB4FFFF83 (CBZ X3,-4), then 0x14000010 (B +16) -> imm=0xFFFFFFFFFFFFFFFC with fmt=2, then imm=0x10 with fmt=3, in order.
- Push 0x913FFC00 (ADDI #4095) -> imm=0xFFF, fmt=4. Push 0xD2F7DDE5 (MOVZ #0xBEEF, LSL 48) -> imm=0xBEEF000000000000, fmt=5.
- DEPTH=2, out_ready=0, hold in_valid high with 3 distinct words -> in_ready=0 after 2 accepts and the third word is held. Raise out_ready -> all 3 emerge in order. Push and pop in the same cycle leave count unchanged.
- Push 0x8B020020 (ADD reg) ×3 -> illegal=1, imm=0, fmt=0, illegal_cnt=3. Preload the count to 0xFFFF and push another illegal word -> illegal_cnt stays 0xFFFF.
- Fill the queue, pull reset low mid-stream -> out_valid=0 and illegal_cnt=0 immediately without a clock edge. After release, push one D word -> it is the only output.
- N=32, MOVZ with hw=2 -> illegal=1. ENABLE_IW=0, MOVZ -> illegal=1.
